// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencer for a tiny 4-register machine driving an external ALU.
// It takes one 16-bit instruction at a time and handles it in one of two ways:
//   ld=1 : IDLE -> WB, with the immediate as the write-back value
//   ld=0 : IDLE -> EXEC -> WB, with the ALU result (or zero flag for SLT/SEQ)
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   instr_valid_i/instr_i   instruction offer; instr_ready_o accepts it (IDLE only)
//   rs_o, rt_o, opcode_o    registered ALU operands/opcode (held outside EXEC)
//   alu_result_i, zero_i    combinational ALU return, sampled at EXEC exit
//   done_o, result_o        1-cycle WB pulse and held write-back value
//   flag_o                  zero_i captured from the last ALU op
//   dbg_addr_i, dbg_data_o  combinational register-file read
module alu_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        instr_valid_i,
  input  logic [15:0] instr_i,
  output logic        instr_ready_o,
  output logic [7:0]  rs_o,
  output logic [7:0]  rt_o,
  output logic [2:0]  opcode_o,
  input  logic [7:0]  alu_result_i,
  input  logic        zero_i,
  output logic        done_o,
  output logic [7:0]  result_o,
  output logic        flag_o,
  input  logic [1:0]  dbg_addr_i,
  output logic [7:0]  dbg_data_o
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned NREGS  = 4;

  localparam logic [OP_W-1:0] OP_SLT = 3'b101;
  localparam logic [OP_W-1:0] OP_SEQ = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] regs [NREGS];
  logic [IDX_W-1:0]  rd_q;
  logic [DATA_W-1:0] rs_q, rt_q, result_q;
  logic [OP_W-1:0]   op_q;
  logic              done_q, flag_q, ready_q;

  // Instruction field decode
  logic              ld_c;
  logic [OP_W-1:0]   op_c;
  logic [IDX_W-1:0]  rd_c, rs_c, rt_c;
  logic [DATA_W-1:0] imm_c;
  logic              accept_c;
  logic [DATA_W-1:0] wb_value_c;

  assign ld_c  = instr_i[15];
  assign op_c  = instr_i[14:12];
  assign rd_c  = instr_i[11:10];
  assign rs_c  = instr_i[9:8];
  assign rt_c  = instr_i[1:0];
  assign imm_c = instr_i[7:0];

  assign accept_c = instr_valid_i && (state_q == IDLE);

  // Compare ops write back only the ALU's zero indication
  assign wb_value_c = ((op_q == OP_SLT) || (op_q == OP_SEQ)) ? DATA_W'(zero_i)
                                                             : alu_result_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = ld_c ? WB : EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      op_q     <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q  <= 1'b0;
      ready_q <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            rd_q <= rd_c;
            if (ld_c) begin
              result_q <= imm_c;
              done_q   <= 1'b1;
            end else begin
              // Any earlier WB has already retired, so the file is current here
              rs_q <= regs[rs_c];
              rt_q <= regs[rt_c];
              op_q <= op_c;
            end
          end
        end
        EXEC: begin
          result_q <= wb_value_c;
          flag_q   <= zero_i;
          done_q   <= 1'b1;
        end
        WB: regs[rd_q] <= result_q;
        default: ;
      endcase
    end
  end

  assign instr_ready_o = ready_q;
  assign rs_o          = rs_q;
  assign rt_o          = rt_q;
  assign opcode_o      = op_q;
  assign done_o        = done_q;
  assign result_o      = result_q;
  assign flag_o        = flag_q;
  assign dbg_data_o    = regs[dbg_addr_i];

endmodule
